// File: rtl/tb_path_scorer_pkg.sv
// Shared constants, FSM state type and saturating-add helper for the
// Needleman-Wunsch traceback scorer.
package tb_pkg;

    localparam logic [2:0] SYM_DIAG = 3'b001;
    localparam logic [2:0] SYM_LEFT = 3'b100;
    localparam logic [2:0] SYM_UP   = 3'b010;

    // Truncated to CHAR_W by the user, so the gap code is always all ones.
    localparam logic [31:0] DASH_DEFAULT = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int sat_add(input int a, input int b, input int unsigned w);
        longint sum;
        longint hi;
        longint lo;
        sum = longint'(a) + longint'(b);
        hi  = (longint'(1) << (w - 1)) - 1;
        lo  = -(longint'(1) << (w - 1));
        if (sum > hi) begin
            return int'(hi);
        end else if (sum < lo) begin
            return int'(lo);
        end
        return int'(sum);
    endfunction

endpackage

// File: rtl/tb_path_scorer_if.sv
// Traceback step input stream and aligned-pair output stream.
interface tb_path_scorer_if #(
    parameter int unsigned CHAR_W = 3
) ();

    logic              in_valid;
    logic              in_ready;
    logic [2:0]        symbol;
    logic [CHAR_W-1:0] seq_a_char;
    logic [CHAR_W-1:0] seq_b_char;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [CHAR_W-1:0] out_a;
    logic [CHAR_W-1:0] out_b;
    logic              out_last;

    modport master (
        output in_valid, symbol, seq_a_char, seq_b_char, in_last, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_last
    );

    modport slave (
        input  in_valid, symbol, seq_a_char, seq_b_char, in_last, out_ready,
        output in_ready, out_valid, out_a, out_b, out_last
    );

endinterface

// File: rtl/tb_score_acc.sv
// Saturating signed accumulator with synchronous clear and enable.
module tb_score_acc
    import tb_pkg::*;
#(
    parameter int unsigned SCORE_W = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_clr,
    input  logic                      i_en,
    input  logic signed [SCORE_W-1:0] i_incr,
    output logic signed [SCORE_W-1:0] o_acc
);

    logic signed [SCORE_W-1:0] r_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= SCORE_W'(sat_add(int'(r_acc), int'(i_incr), SCORE_W));
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/tb_path_scorer.sv
// Traceback back-end: turns arrow steps into aligned character pairs,
// accumulating score and path length until the last step.
module tb_path_scorer
    import tb_pkg::*;
#(
    parameter int unsigned        N              = 128,
    parameter int unsigned        CHAR_W         = 3,
    parameter int unsigned        SCORE_W        = 10,
    parameter int                 MATCH_SCORE    = 1,
    parameter int                 MISMATCH_SCORE = -1,
    parameter int                 GAP_SCORE      = -2,
    parameter logic [CHAR_W-1:0]  DASH           = CHAR_W'(DASH_DEFAULT),
    localparam int unsigned       PLEN_W         = $clog2(2 * N + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    tb_path_scorer_if.slave           bus,
    output logic signed [SCORE_W-1:0] final_score,
    output logic [PLEN_W-1:0]         path_len,
    output logic                      done,
    output logic                      err,
    output logic                      busy
);

    localparam logic [PLEN_W-1:0] MAX_LEN = PLEN_W'(2 * N);

    state_t                    r_state;
    state_t                    w_next_state;
    logic                      w_in_ready;
    logic                      w_accept;
    logic                      w_sym_legal;
    logic                      w_clear;
    logic signed [SCORE_W-1:0] w_incr;
    logic signed [SCORE_W-1:0] w_score;
    logic [CHAR_W-1:0]         w_pair_a;
    logic [CHAR_W-1:0]         w_pair_b;
    logic                      r_out_valid;
    logic [CHAR_W-1:0]         r_out_a;
    logic [CHAR_W-1:0]         r_out_b;
    logic                      r_out_last;
    logic [PLEN_W-1:0]         r_path_len;
    logic                      r_err;

    assign w_in_ready  = (r_state == ST_RUN) && (!r_out_valid || bus.out_ready);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_sym_legal = (bus.symbol == SYM_DIAG) || (bus.symbol == SYM_LEFT) ||
                         (bus.symbol == SYM_UP);
    assign w_clear     = (r_state == ST_IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: if (start) w_next_state = ST_RUN;
            ST_RUN:  if (w_accept && bus.in_last) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_pair_a = bus.seq_a_char;
        w_pair_b = bus.seq_b_char;
        w_incr   = SCORE_W'(GAP_SCORE);
        if (bus.symbol == SYM_DIAG) begin
            w_incr = (bus.seq_a_char == bus.seq_b_char) ? SCORE_W'(MATCH_SCORE)
                                                        : SCORE_W'(MISMATCH_SCORE);
        end else if (bus.symbol == SYM_LEFT) begin
            w_pair_a = DASH;
        end else if (bus.symbol == SYM_UP) begin
            w_pair_b = DASH;
        end
    end

    // Reload on a legal acceptance even while the old pair leaves, so there is no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_out_last  <= 1'b0;
        end else if (w_accept && w_sym_legal) begin
            r_out_valid <= 1'b1;
            r_out_a     <= w_pair_a;
            r_out_b     <= w_pair_b;
            r_out_last  <= bus.in_last;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_path_len <= '0;
            r_err      <= 1'b0;
        end else if (w_clear) begin
            r_path_len <= '0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            if (!w_sym_legal || (r_path_len == MAX_LEN)) begin
                r_err <= 1'b1;
            end else begin
                r_path_len <= r_path_len + PLEN_W'(1);
            end
        end
    end

    tb_score_acc #(
        .SCORE_W (SCORE_W)
    ) u_score_acc (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clear),
        .i_en   (w_accept && w_sym_legal),
        .i_incr (w_incr),
        .o_acc  (w_score)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_a     = r_out_a;
    assign bus.out_b     = r_out_b;
    assign bus.out_last  = r_out_last;
    assign final_score   = w_score;
    assign path_len      = r_path_len;
    assign done          = (r_state == ST_DONE);
    assign err           = r_err;
    assign busy          = (r_state != ST_IDLE);

endmodule

// File: doc/tb_path_scorer.md
Name: tb_path_scorer

Overview:
- Next-generation traceback back-end for the Needleman-Wunsch pipeline.
- Consumes one traceback step per valid/ready handshake: arrow symbol plus the SeqA and SeqB characters at the current cell.
- Emits the aligned character pair, with dash substitution, on a registered output stream with backpressure.
- Accumulates the alignment score and path length, then reports a one-cycle result strobe when the path ends.

Parameters:
- N, 128, maximum sequence length; the longest path is 2*N steps.
- CHAR_W, 3, width of one sequence character.
- SCORE_W, 10, width of the signed score accumulator.
- MATCH_SCORE, 1, added on a diagonal step with equal characters.
- MISMATCH_SCORE, -1, added on a diagonal step with different characters.
- GAP_SCORE, -2, added on a left or up step.
- DASH, 3'b111 (CHAR_W bits of 1), gap character code.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  begin a new path; honoured only in IDLE
- in_valid  in  1  step present
- in_ready  out  1  step accepted when in_valid&&in_ready
- symbol  in  3  001 diagonal, 100 left, 010 up
- seq_a_char  in  CHAR_W  SeqA character at the current cell
- seq_b_char  in  CHAR_W  SeqB character at the current cell
- in_last  in  1  final step of the path
- out_valid  out  1  aligned pair present
- out_ready  in  1  downstream accepts the pair
- out_a  out  CHAR_W  aligned SeqA character or DASH
- out_b  out  CHAR_W  aligned SeqB character or DASH
- out_last  out  1  pair belongs to the final step
- final_score  out  SCORE_W  signed accumulated score
- path_len  out  $clog2(2*N+1)  number of accepted steps
- done  out  1  one-cycle strobe: final_score and path_len are valid
- err  out  1  sticky: illegal symbol or overlong path
- busy  out  1  state != IDLE

Behaviour:
- Reset is asynchronous and active-high on rst; clock is clk. At reset:
  - state = IDLE.
  - All outputs = 0.
  - out_a and out_b = 0.
  - A reset mid-path drops the path; no done is issued.
- State machine IDLE -> RUN -> DONE -> IDLE:
  - IDLE to RUN: start=1. Also clears final_score, path_len and err.
  - RUN to DONE: on an accepted step with in_last=1.
  - DONE to IDLE: unconditional after one cycle. done=1 only while in DONE.
- start is ignored outside IDLE.
- in_ready = (state==RUN) && (!out_valid || out_ready). This is a single-stage pipeline register.
- Simultaneous out handshake and new acceptance: the register reloads in the same cycle; there is no bubble.
- On acceptance, the output register loads one cycle later (latency 1). out_valid holds until out_ready=1.
  - Diagonal: out_a = seq_a_char, out_b = seq_b_char.
  - Left: out_a = DASH, out_b = seq_b_char.
  - Up: out_a = seq_a_char, out_b = DASH.
- Score update: computed from the input characters, not from the registered outputs, and registered on acceptance.
  - Diagonal: +MATCH_SCORE if the characters are equal, otherwise +MISMATCH_SCORE.
  - Left or up: +GAP_SCORE.
  - Sums saturate at the signed SCORE_W limits and do not wrap.
- path_len increments on every acceptance.
  - An acceptance beyond 2*N steps sets err. path_len then holds at 2*N.
- Illegal symbol (any value other than 001/100/010) on acceptance:
  - The step is consumed.
  - No output pair is produced and there is no score or length change.
  - err is set.
  - If in_last=1 on the illegal step, the block still goes to DONE.
- done asserts in the cycle after the last acceptance, with final results. The final out pair may still be stalled; done does not wait for it.
- The out register retains its content through DONE and IDLE until it is consumed.

Decomposition:
- Package tb_pkg holds:
  - The symbol constants SYM_DIAG, SYM_LEFT, SYM_UP.
  - The DASH default.
  - The state enum.
  - The sat_add function.
- Sub-module tb_score_acc: saturating signed accumulator with clear/enable. It is reused by future affine-gap variants.

Test Plan:
- Reset mid-path (rst pulsed after 3 steps) -> all outputs 0, state IDLE, no done; a subsequent full path scores correctly.
- start; steps diag(A=2,B=2), left(B=5), up(A=1), diag(A=3,B=4, last) with out_ready=1 -> pairs (2,2),(7,5),(1,7),(3,4); out_last on the 4th pair; done with final_score=-4, path_len=4.
- Same stream with out_ready held 0 for 5 cycles after the first pair -> in_ready=0 while out_valid; no pair lost or duplicated; identical results.
- Symbol 011 mid-path -> err=1, no pair emitted for that step, score unchanged; later steps are processed normally.
- 2*N+1 left steps with SCORE_W=6 -> final_score saturates at -32, path_len=256, err=1.
- start pulsed during RUN -> ignored; score and length are not cleared.
